// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, data-width decode and parity-type constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam logic PARITY_EVEN = 1'b1;
    localparam logic PARITY_ODD  = 1'b0;

    function automatic logic [7:0] dataMask(input logic [1:0] num);
        case (num)
            DBITS_5: dataMask = 8'h1F;
            DBITS_6: dataMask = 8'h3F;
            DBITS_7: dataMask = 8'h7F;
            DBITS_8: dataMask = 8'hFF;
            default: dataMask = 8'hFF;
        endcase
    endfunction

    // Index of the last data bit, so the DATA state can compare against a 3-bit counter
    function automatic logic [2:0] lastBitIdx(input logic [1:0] num);
        case (num)
            DBITS_5: lastBitIdx = 3'd4;
            DBITS_6: lastBitIdx = 3'd5;
            DBITS_7: lastBitIdx = 3'd6;
            DBITS_8: lastBitIdx = 3'd7;
            default: lastBitIdx = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: o_bit_end marks the last tick of a bit period.
// Held at zero while i_clear is high so every frame starts on a fresh bit.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] r_count;

    assign o_bit_end = i_tick && (r_count == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 5-8 data bits, optional parity, 1/2 stop bits, LSB first.
// Define UART_TX_CTS_EN to make acceptance additionally wait for i_cts_n low.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    input  logic [1:0] i_data_bit_num,
    input  logic       i_stop_bit_num,
    input  logic       i_parity_en,
    input  logic       i_parity_type,
    input  logic       i_cts_n,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bitCnt;
    logic [2:0] r_lastBit;
    logic       r_stopTwo;
    logic       r_stopCnt;
    logic       r_parEn;
    logic       r_parBit;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;

    logic       w_bitEnd;
    logic       w_ctsOk;
    logic       w_accept;
    logic [7:0] w_masked;
    logic       w_parBit;

`ifdef UART_TX_CTS_EN
    assign w_ctsOk = ~i_cts_n;
`else
    // Flow control compiled out: cts_n is referenced but can never block acceptance
    assign w_ctsOk = 1'b1 | i_cts_n;
`endif

    // r_done gates acceptance so a request coinciding with the done pulse waits one clk
    assign w_accept = (r_state == ST_IDLE) && i_tx_start && !r_done && w_ctsOk;
    assign w_masked = i_tx_data & dataMask(i_data_bit_num);

    always_comb begin
        w_parBit = 1'b0;
        case (i_parity_type)
            PARITY_EVEN: w_parBit = ^w_masked;
            PARITY_ODD:  w_parBit = ~^w_masked;
            default:     w_parBit = 1'b0;
        endcase
    end

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_tick   (i_tick),
        .i_clear  (r_state == ST_IDLE),
        .o_bit_end(w_bitEnd)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_lastBit <= '0;
            r_stopTwo <= 1'b0;
            r_stopCnt <= 1'b0;
            r_parEn   <= 1'b0;
            r_parBit  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_shift   <= w_masked;
                        r_lastBit <= lastBitIdx(i_data_bit_num);
                        r_stopTwo <= i_stop_bit_num;
                        r_parEn   <= i_parity_en;
                        r_parBit  <= w_parBit;
                        r_bitCnt  <= '0;
                        r_stopCnt <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bitEnd) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_bitEnd) begin
                        if (r_bitCnt == r_lastBit) begin
                            r_state <= r_parEn ? ST_PARITY : ST_STOP;
                            r_tx    <= r_parEn ? r_parBit : 1'b1;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bitEnd) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bitEnd) begin
                        if (r_stopCnt == r_stopTwo) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_stopCnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected frames are queued at request time and
// compared bit by bit at mid-bit as the line is observed.
module tb_uart_tx;

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       txStart;
    logic [7:0] txData;
    logic [1:0] dataBitNum;
    logic       stopBitNum;
    logic       parityEn;
    logic       parityType;
    logic       ctsN;
    logic       tx;
    logic       txBusy;
    logic       txDone;

    frame_t expQ[$];
    int     checks    = 0;
    int     errors    = 0;
    int     doneCount = 0;

    uart_tx #(
        .OVERSAMPLE(16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tick        (tick),
        .i_tx_start    (txStart),
        .i_tx_data     (txData),
        .i_data_bit_num(dataBitNum),
        .i_stop_bit_num(stopBitNum),
        .i_parity_en   (parityEn),
        .i_parity_type (parityType),
        .i_cts_n       (ctsN),
        .o_tx          (tx),
        .o_tx_busy     (txBusy),
        .o_tx_done     (txDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk tick every fourth clock, so a bit period is 64 clocks
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (txDone === 1'b1) doneCount++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic frame_t makeFrame(input logic [7:0] d, input logic [1:0] dbn,
                                         input logic s2, input logic pe, input logic pt);
        frame_t f;
        int     n;
        int     k;
        logic   p;
        f.bits = '0;
        n = 5 + int'(dbn);
        k = 0;
        p = 1'b0;
        f.bits[k] = 1'b0;
        k++;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (pe) begin
            f.bits[k] = pt ? p : ~p;
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        if (s2) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len = k;
        return f;
    endfunction

    // Drives one request for a single clock and queues the frame it should produce
    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] dbn,
                                 input logic s2, input logic pe, input logic pt);
        @(negedge clk);
        txData     = d;
        dataBitNum = dbn;
        stopBitNum = s2;
        parityEn   = pe;
        parityType = pt;
        txStart    = 1'b1;
        expQ.push_back(makeFrame(d, dbn, s2, pe, pt));
        @(negedge clk);
        txStart = 1'b0;
    endtask

    // Waits for the start bit, samples each bit mid-period, then checks the done pulse
    task automatic receiveFrame(input string tag);
        frame_t f;
        int     t;
        if (expQ.size() == 0) begin
            checkOutput({tag, " queue"}, 32'(expQ.size()), 32'd1);
            return;
        end
        f = expQ.pop_front();
        t = 0;
        while (tx !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checkOutput({tag, " start-seen"}, 32'(t < 2000), 32'd1);
        repeat (32) @(negedge clk);
        for (int i = 0; i < f.len; i++) begin
            checkOutput($sformatf("%s bit%0d", tag, i), 32'(tx), 32'(f.bits[i]));
            checkOutput($sformatf("%s busy%0d", tag, i), 32'(txBusy), 32'd1);
            if (i < f.len - 1) repeat (64) @(negedge clk);
        end
        t = 0;
        while (txDone !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checkOutput({tag, " done-seen"}, 32'(txDone), 32'd1);
        checkOutput({tag, " busy-at-done"}, 32'(txBusy), 32'd0);
        checkOutput({tag, " tx-at-done"}, 32'(tx), 32'd1);
        @(negedge clk);
        checkOutput({tag, " done-width"}, 32'(txDone), 32'd0);
    endtask

    initial begin
        int dc;
        int n;
        int lowSeen;
        rst        = 1'b1;
        txStart    = 1'b0;
        txData     = 8'h00;
        dataBitNum = 2'b11;
        stopBitNum = 1'b0;
        parityEn   = 1'b0;
        parityType = 1'b0;
        ctsN       = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset tx", 32'(tx), 32'd1);
        checkOutput("reset busy", 32'(txBusy), 32'd0);
        checkOutput("reset done", 32'(txDone), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("idle tx", 32'(tx), 32'd1);

        // 8N1 0x55
        dc = doneCount;
        applyStimulus(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        checkOutput("8N1 accept-latency tx", 32'(tx), 32'd0);
        receiveFrame("8N1");
        repeat (10) @(negedge clk);
        checkOutput("8N1 done-count", 32'(doneCount - dc), 32'd1);
        checkOutput("8N1 busy-after", 32'(txBusy), 32'd0);

        // 5E2 0xF3: only the low five bits go out
        applyStimulus(8'hF3, 2'b00, 1'b1, 1'b1, 1'b1);
        receiveFrame("5E2");

        // 7O1 0x00 with inputs disturbed and a second request mid-frame
        dc = doneCount;
        applyStimulus(8'h00, 2'b10, 1'b0, 1'b1, 1'b0);
        fork
            receiveFrame("7O1");
            begin
                repeat (100) @(negedge clk);
                txData     = 8'hFF;
                dataBitNum = 2'b00;
                stopBitNum = 1'b1;
                parityEn   = 1'b0;
                parityType = 1'b1;
                txStart    = 1'b1;
                @(negedge clk);
                txStart = 1'b0;
            end
        join
        repeat (200) @(negedge clk);
        checkOutput("7O1 single-frame", 32'(doneCount - dc), 32'd1);
        checkOutput("7O1 idle-tx", 32'(tx), 32'd1);

        // tx_start held high: two frames with a fixed idle gap
        @(negedge clk);
        txData     = 8'hA5;
        dataBitNum = 2'b11;
        stopBitNum = 1'b0;
        parityEn   = 1'b0;
        txStart    = 1'b1;
        expQ.push_back(makeFrame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0));
        expQ.push_back(makeFrame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0));
        receiveFrame("b2b first");
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b gap", 32'(n), 32'd1);
        txStart = 1'b0;
        receiveFrame("b2b second");
        repeat (100) @(negedge clk);
        checkOutput("b2b stop-after-release", 32'(txBusy), 32'd0);

        // Reset in the middle of data bit 3
        applyStimulus(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
        void'(expQ.pop_back());
        repeat (288) @(negedge clk);
        checkOutput("rst-mid pre-tx", 32'(tx), 32'd0);
        dc = doneCount;
        #1 rst = 1'b1;
        #1;
        checkOutput("rst-mid async-tx", 32'(tx), 32'd1);
        checkOutput("rst-mid async-busy", 32'(txBusy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("rst-mid no-done", 32'(doneCount - dc), 32'd0);
        checkOutput("rst-mid idle-tx", 32'(tx), 32'd1);
        applyStimulus(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
        receiveFrame("post-rst");

        // Flow control
        @(negedge clk);
        txData     = 8'h96;
        dataBitNum = 2'b11;
        stopBitNum = 1'b0;
        parityEn   = 1'b1;
        parityType = 1'b1;
        ctsN       = 1'b1;
        txStart    = 1'b1;
        expQ.push_back(makeFrame(8'h96, 2'b11, 1'b0, 1'b1, 1'b1));
`ifdef UART_TX_CTS_EN
        lowSeen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lowSeen++;
        end
        checkOutput("cts held-off tx", 32'(lowSeen), 32'd0);
        checkOutput("cts held-off busy", 32'(txBusy), 32'd0);
        ctsN = 1'b0;
        @(negedge clk);
        txStart = 1'b0;
        checkOutput("cts release start", 32'(tx), 32'd0);
`else
        lowSeen = 0;
        @(negedge clk);
        txStart = 1'b0;
        checkOutput("cts ignored start", 32'(tx), 32'd0);
        checkOutput("cts ignored busy", 32'(txBusy), 32'd1);
`endif
        receiveFrame("cts frame");
        ctsN = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("final queue-empty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter, the transmit-side counterpart of the group's UART receiver.
- Shares the 16x-oversample `tick` enable from the baud generator.
- Shares the same runtime frame configuration: 5–8 data bits, 1/2 stop bits, optional even/odd parity.
- Serialises one byte per accepted request, LSB first, and supports RTS/CTS-style flow control.

Parameters:
OVERSAMPLE, 16, ticks per bit period; the tick counter width is $clog2(OVERSAMPLE).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
tick  input  1  baud enable, one clk wide, OVERSAMPLE per bit
tx_start  input  1  transmit request, sampled every clk
tx_data  input  8  byte to send; bits above the configured width are ignored
data_bit_num  input  2  00=5, 01=6, 10=7, 11=8 data bits
stop_bit_num  input  1  0=1 stop bit, 1=2 stop bits
parity_en  input  1  1=insert parity bit after data
parity_type  input  1  1=even parity, 0=odd parity
cts_n  input  1  clear-to-send from far receiver, active low (used only with UART_TX_CTS_EN)
tx  output  1  serial line, idle high
tx_busy  output  1  high from request acceptance until frame end
tx_done  output  1  one-clk pulse at frame completion

Behaviour:
- **Reset (async):** tx=1, tx_busy=0, tx_done=0, state=IDLE, all counters and shift register cleared. Reset mid-frame aborts the frame immediately and the line returns high; no tx_done is produced.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- **IDLE:**
  - tx=1.
  - Accept on any clk edge where tx_start=1 (plus CTS condition, see Optional Feature).
  - On acceptance, latch tx_data, bit count, stop count, parity_en and parity_type into internal registers; later input changes do not affect the frame.
  - Go to START with tx_busy=1.
- **START:** tx=0 from the clk after acceptance. Leave after OVERSAMPLE ticks (tick counter 0..15; exit on the tick where counter==15).
- **DATA:**
  - tx = shift[0]; shift right on each bit boundary.
  - Each bit lasts OVERSAMPLE ticks.
  - After N bits, go to PARITY if parity is latched enabled, else to STOP.
- **PARITY:** tx = XOR of the N data bits (even), or its inverse (odd). Lasts OVERSAMPLE ticks.
- **STOP:**
  - tx=1 for 1 or 2 bit periods.
  - On the final tick: go to IDLE, tx_busy→0, tx_done=1 for exactly one clk.
- **tx_start while busy:** ignored, not queued.
- **Back-to-back:** tx_start asserted in the same clk that tx_done pulses is not accepted; it is accepted on the next clk if still high. The minimum idle gap is therefore one clk.
- **Frame length:** (1 + N + P + S) × OVERSAMPLE ticks, plus 1 clk acceptance latency.
- **Tick timing:** ticks arriving during IDLE have no effect. The tick counter restarts at 0 on acceptance.

Optional Feature:
UART_TX_CTS_EN.
- **Defined:** acceptance additionally requires cts_n==0. A request held with cts_n=1 waits (tx_start must stay high). cts_n deasserting mid-frame never truncates the frame; it only blocks the next acceptance.
- **Undefined:** cts_n is ignored (port kept, unused).

Decomposition:
- **Package uart_pkg:**
  - State encodings IDLE..STOP (3-bit), shared with the receiver.
  - Data-bit-num decode constants (5/6/7/8).
  - Parity-type constants EVEN=1, ODD=0.
- **Sub-module uart_bit_timer:** tick counter with clear input; asserts bit_end when counter==OVERSAMPLE-1 and tick=1. Reusable by the receiver.
- FSM and shift/parity logic stay in uart_tx.

Test Plan:
- 8N1, tx_data=0x55, tick every 4 clk → line 0,1,0,1,0,1,0,1,0,1 (start..stop), each bit 16 ticks; tx_done pulses once; tx_busy low after.
- 5E2, tx_data=0xF3 (data 10011) → 5 data bits LSB first 1,1,0,0,1; parity bit 1; two stop bits; bits 7:5 never appear on the line.
- 7O1, tx_data=0x00 → parity bit 1; change tx_data/config mid-frame → transmitted frame unchanged.
- tx_start held high continuously → consecutive frames separated by exactly one idle clk plus the next start; a second pulse mid-frame is ignored (one frame only).
- Assert rst during DATA bit 3 → tx=1 on the same cycle (async), tx_busy=0, no tx_done; next request transmits a full correct frame.
- With UART_TX_CTS_EN: cts_n=1 while tx_start=1 for 100 clk → tx stays 1; cts_n→0 → START begins next clk. Without the macro → START begins regardless of cts_n.
